// File: rtl/register_write_arbiter.sv
// register_write_arbiter: shares one external register among N writers (round-robin, or
// fixed priority with lowest index winning when REG_ARB_FIXED_PRIO_EN is defined).
module register_write_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] wdata,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       ack,
    output logic [WIDTH-1:0]   reg_in,
    output logic               reg_load,
    output logic               busy
);
    localparam int PW = $clog2(N);
    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
    state_t state, state_nxt;
    logic [PW-1:0] w;
    logic [N-1:0] gnt_nxt, ack_nxt;
    logic [WIDTH-1:0] reg_in_nxt;
    logic load_nxt;
`ifdef REG_ARB_FIXED_PRIO_EN
    always_comb begin
        w = '0;
        for (int k = N - 1; k >= 0; k--) if (req[k]) w = PW'(k);
    end
`else
    logic [PW-1:0] ptr, ptr_nxt, win, win_nxt, off;
    logic [N-1:0] rot;
    logic [PW:0] sum;
    // rotate so bit 0 is the requester at ptr, then map the first hit back to an index
    assign rot = N'({req, req} >> ptr);
    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--) if (rot[k]) off = PW'(k);
        sum = {1'b0, ptr} + {1'b0, off};
        w = PW'(sum >= (PW+1)'(N) ? sum - (PW+1)'(N) : sum);
    end
`endif
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        ack_nxt    = '0;
        reg_in_nxt = reg_in;
        load_nxt   = 1'b0;
`ifndef REG_ARB_FIXED_PRIO_EN
        win_nxt    = win;
        ptr_nxt    = ptr;
`endif
        unique case (state)
            IDLE: if (|req) begin
                state_nxt  = GRANT;
                gnt_nxt    = N'(1) << w;
                reg_in_nxt = wdata[int'(w)*WIDTH +: WIDTH];
                load_nxt   = 1'b1;
`ifndef REG_ARB_FIXED_PRIO_EN
                win_nxt    = w;
`endif
            end
            GRANT: begin
                state_nxt = ACK;
                ack_nxt   = gnt;
            end
            ACK: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
`ifndef REG_ARB_FIXED_PRIO_EN
                ptr_nxt   = (win == PW'(N - 1)) ? '0 : win + PW'(1);
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            ack      <= '0;
            reg_in   <= '0;
            reg_load <= 1'b0;
            busy     <= 1'b0;
`ifndef REG_ARB_FIXED_PRIO_EN
            ptr      <= '0;
            win      <= '0;
`endif
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            ack      <= ack_nxt;
            reg_in   <= reg_in_nxt;
            reg_load <= load_nxt;
            busy     <= state_nxt != IDLE;
`ifndef REG_ARB_FIXED_PRIO_EN
            ptr      <= ptr_nxt;
            win      <= win_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_register_write_arbiter.sv
// tb_register_write_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_register_write_arbiter;
    localparam int N = 4;
    localparam int W = 16;
    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] req;
    logic [N*W-1:0] wdata;
    logic [N-1:0] gnt, ack;
    logic [W-1:0] reg_in;
    logic reg_load, busy;
    logic [W-1:0] reg_out = '0;
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int age = 0;
    int m_w = 0;
    int m_ptr = 0;
    logic [W-1:0] m_data = '0;
    logic [W-1:0] m_reg = '0;

    always #5 clk = ~clk;

    register_write_arbiter #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .gnt(gnt), .ack(ack),
        .reg_in(reg_in), .reg_load(reg_load), .busy(busy)
    );

    // the external Register
    always @(posedge clk) if (reg_load) reg_out <= reg_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        int s = p;
`ifdef REG_ARB_FIXED_PRIO_EN
        s = 0;
`endif
        for (int k = 0; k < N; k++) if (r[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    // model: age 0 = no write, 1 = load cycle, 2 = ack cycle
    always @(posedge clk) begin
        if (age == 1) m_reg = m_data;
        if (reset) begin
            age = 0;
            m_ptr = 0;
        end else if (age == 1) age = 2;
        else if (age == 2) begin
            age = 0;
            m_ptr = (m_w + 1) % N;
        end else if (req != 0) begin
            m_w = pick(req, m_ptr);
            m_data = wdata[m_w*W +: W];
            age = 1;
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("gnt", 32'(gnt), age != 0 ? 32'(1) << m_w : 32'(0));
        chk("ack", 32'(ack), age == 2 ? 32'(1) << m_w : 32'(0));
        chk("reg_load", 32'(reg_load), 32'(age == 1));
        chk("busy", 32'(busy), 32'(age != 0));
        chk("reg_out", 32'(reg_out), 32'(m_reg));
        if (age == 1) chk("reg_in", 32'(reg_in), 32'(m_data));
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n, edges, loads;
        int order[4];
        bit drop0, done, changed;
        reset = 1'b1;
        req = '1;
        wdata = '0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_ack", 32'(ack), 0);
            chk("rst_load", 32'(reg_load), 0);
            chk("rst_reg_in", 32'(reg_in), 0);
            chk("rst_busy", 32'(busy), 0);
        end
        reset = 1'b0;
        req = '0;
        // single write
        @(negedge clk);
        req = 4'b0100;
        wdata[2*W +: W] = 16'hBEEF;
        loads = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (reg_load) begin
                loads++;
                chk("t2_reg_in", 32'(reg_in), 32'hBEEF);
            end
            if (ack != 0) begin
                chk("t2_ack", 32'(ack), 32'b0100);
                chk("t2_reg_out", 32'(reg_out), 32'hBEEF);
                req = '0;
                done = 1'b1;
            end
        end
        chk("t2_done", 32'(done), 1);
        chk("t2_loads", 32'(loads), 1);
        // all four requesting, each drops after its ack
        do_reset();
        req = '1;
        n = 0;
        edges = 0;
        for (int c = 0; c < 40 && !(n == 4 && !busy); c++) begin
            @(negedge clk);
            edges++;
            if (ack != 0 && n < 4) begin
                order[n] = $clog2(ack);
                req = req & ~ack;
                n++;
            end
        end
        chk("t3_acks", 32'(n), 4);
        chk("t3_cycles", 32'(edges), 12);
        for (int i = 0; i < 4; i++) chk("t3_order", 32'(order[i]), 32'(i));
        // requester 0 re-requests at once, requester 3 holds
        do_reset();
        req = 4'b1001;
        n = 0;
        drop0 = 1'b0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (drop0) begin
                req[0] = 1'b1;
                drop0 = 1'b0;
            end
            if (ack != 0) begin
                order[n] = $clog2(ack);
                n++;
                if (ack[0]) begin
                    req[0] = 1'b0;
                    drop0 = 1'b1;
                end
            end
        end
        chk("t4_acks", 32'(n), 4);
`ifdef REG_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) chk("t4_order", 32'(order[i]), 0);
`else
        for (int i = 0; i < 4; i++) chk("t4_order", 32'(order[i]), (i % 2) ? 3 : 0);
`endif
        req = '0;
        repeat (4) @(negedge clk);
        // withdraw and data change during GRANT
        req = 4'b0010;
        wdata[W +: W] = 16'h1234;
        done = 1'b0;
        changed = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (gnt[1] && !changed) begin
                req[1] = 1'b0;
                wdata[W +: W] = 16'hFFFF;
                changed = 1'b1;
            end
            if (ack != 0) begin
                chk("t5_ack", 32'(ack), 32'b0010);
                chk("t5_reg_out", 32'(reg_out), 32'h1234);
                done = 1'b1;
            end
        end
        chk("t5_done", 32'(done), 1);
        // reset during GRANT
        @(negedge clk);
        req = 4'b0001;
        wdata[0 +: W] = 16'h5A5A;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (reg_load) done = 1'b1;
        end
        chk("t6_load_seen", 32'(done), 1);
        reset = 1'b1;
        req = '0;
        @(negedge clk);
        chk("t6_reg_out", 32'(reg_out), 32'h5A5A);
        chk("t6_ack", 32'(ack), 0);
        chk("t6_gnt", 32'(gnt), 0);
        chk("t6_busy", 32'(busy), 0);
        reset = 1'b0;
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if (ack[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
                else if (req[i] && $urandom_range(0, 19) == 0) req[i] = 1'b0;
            end
            wdata = {$urandom, $urandom};
        end
        reset = 1'b0;
        req = '0;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
